// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared state encoding and default sizing for the TRNG capture path
package trng_pkg;

    localparam int TRNG_ADDR_W    = 17;
    localparam int TRNG_DEPTH     = 100000;
    localparam int TRNG_WARMUP    = 1024;
    localparam int TRNG_REP_LIMIT = 32;

    typedef enum logic [6:0] {
        ST_IDLE    = 7'b000_0001,
        ST_WARMUP  = 7'b000_0010,
        ST_CAPTURE = 7'b000_0100,
        ST_DONE    = 7'b000_1000,
        ST_RD_ADDR = 7'b001_0000,
        ST_RD_WAIT = 7'b010_0000,
        ST_RD_OUT  = 7'b100_0000
    } trng_state_e;

    // A new capture run may only be launched from a quiescent state.
    function automatic logic start_allowed(input trng_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/trng_rep_test.sv
// rtl/trng_rep_test.sv - repetition-count health test over the captured sample stream
module trng_rep_test
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic sample_bit,
    output logic fail
);

    localparam int CNT_W = $clog2(REP_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(REP_LIMIT);

    logic [CNT_W-1:0] run_cnt;
    logic             prev_bit;
    logic             have_prev;

    // Track the current run length; the flag latches one edge after the run hits the limit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            run_cnt   <= '0;
            prev_bit  <= 1'b0;
            have_prev <= 1'b0;
            fail      <= 1'b0;
        end else begin
            if (en) begin
                prev_bit  <= sample_bit;
                have_prev <= 1'b1;
                if (!have_prev || (sample_bit != prev_bit)) begin
                    run_cnt <= CNT_W'(1);
                end else if (run_cnt != LIMIT) begin
                    run_cnt <= run_cnt + CNT_W'(1);
                end
            end
            if (run_cnt == LIMIT) begin
                fail <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/trng_capture_ctrl.sv
// rtl/trng_capture_ctrl.sv - TRNG RO gating, capture sequencing and bitwise readout
module trng_capture_ctrl
    import trng_pkg::*;
#(
    parameter int ADDR_W     = TRNG_ADDR_W,
    parameter int DEPTH      = TRNG_DEPTH,
    parameter int WARMUP_CYC = TRNG_WARMUP,
    parameter int REP_LIMIT  = TRNG_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_in,
    output logic              ro_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic              ram_data,
    input  logic              ram_q,
    input  logic              rd_start,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              health_fail
);

    localparam int WU_W = $clog2(WARMUP_CYC + 1);
    localparam logic [WU_W-1:0]   WU_LAST   = WU_W'(WARMUP_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (WARMUP_CYC < 1) begin : g_bad_warmup
        $error("WARMUP_CYC must be at least 1");
    end
    if (REP_LIMIT < 2) begin : g_bad_rep_limit
        $error("REP_LIMIT must be at least 2");
    end
    if (longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
        $error("DEPTH does not fit in ADDR_W address bits");
    end

    trng_state_e     state;
    logic [WU_W-1:0] wu_cnt;
    logic            run_clr;
    logic            run_en;

    // Samples go straight to the RAM; the write strobe alone decides what is stored.
    assign ram_data = sample_in;

    // The health test restarts with every accepted start and only sees capture cycles.
    assign run_clr = start && !abort && start_allowed(state);
    assign run_en  = (state == ST_CAPTURE);

    trng_rep_test #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rep_test (
        .clk        (clk),
        .rst        (rst),
        .clr        (run_clr),
        .en         (run_en),
        .sample_bit (sample_in),
        .fail       (health_fail)
    );

    // Sequencer: every output is registered and set alongside the state transition.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state    <= ST_IDLE;
            wu_cnt   <= '0;
            ro_en    <= 1'b0;
            ram_addr <= '0;
            ram_wren <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 1'b0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_WARMUP;
                        wu_cnt   <= '0;
                        ro_en    <= 1'b1;
                        ram_addr <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end else if (rd_start && (state == ST_DONE)) begin
                        state    <= ST_RD_ADDR;
                        ram_addr <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                ST_WARMUP: begin
                    if (wu_cnt == WU_LAST) begin
                        state    <= ST_CAPTURE;
                        ram_addr <= '0;
                        ram_wren <= 1'b1;
                    end else begin
                        wu_cnt <= wu_cnt + WU_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (ram_addr == LAST_ADDR) begin
                        state    <= ST_DONE;
                        ram_addr <= '0;
                        ram_wren <= 1'b0;
                        ro_en    <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        ram_addr <= ram_addr + ADDR_W'(1);
                    end
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state    <= ST_RD_OUT;
                    rd_data  <= ram_q;
                    rd_valid <= 1'b1;
                    rd_last  <= (ram_addr == LAST_ADDR);
                end
                ST_RD_OUT: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (ram_addr == LAST_ADDR) begin
                            state    <= ST_DONE;
                            ram_addr <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state    <= ST_RD_ADDR;
                            ram_addr <= ram_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wu_cnt   <= '0;
                    ro_en    <= 1'b0;
                    ram_addr <= '0;
                    ram_wren <= 1'b0;
                    rd_valid <= 1'b0;
                    rd_data  <= 1'b0;
                    rd_last  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_capture_ctrl.sv
// tb/tb_trng_capture_ctrl.sv - randomized self-checking bench for trng_capture_ctrl
module tb_trng_capture_ctrl;

    localparam int ADDR_W     = 4;
    localparam int DEPTH      = 8;
    localparam int WARMUP_CYC = 4;
    localparam int REP_LIMIT  = 5;
    localparam int NCYC       = WARMUP_CYC + DEPTH + 3;
    localparam int AW_D       = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst, start, abort, sample_in, ram_q, rd_start, rd_ready;
    logic              ro_en, ram_wren, ram_data, rd_valid, rd_data, rd_last, busy, done, health_fail;
    logic [ADDR_W-1:0] ram_addr;
    logic              mem [1 << ADDR_W];
    int                checks = 0;
    int                passed = 0;

    always #5 clk = ~clk;

    // Synchronous 1-bit RAM: q shows the word addressed at the previous edge.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    trng_capture_ctrl #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WARMUP_CYC(WARMUP_CYC), .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .sample_in(sample_in),
        .ro_en(ro_en), .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_data(ram_data),
        .ram_q(ram_q), .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .busy(busy), .done(done),
        .health_fail(health_fail)
    );

    // Stimulus driver: launches a run, feeds bits[addr] on each write cycle, stops at done.
    task automatic do_capture(input logic [DEPTH-1:0] bits, output int nwr,
                              output logic f0, output logic ok);
        nwr = 0;
        ok  = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        f0 = health_fail;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (ram_wren) begin
                nwr++;
                sample_in = bits[ram_addr[AW_D-1:0]];
            end else begin
                sample_in = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; sample_in = 1'b0;
        rd_start = 1'b0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ro_en, ram_wren, ram_addr, rd_valid, rd_data, rd_last, busy, done, health_fail} !== '0)
            $display("FAIL reset_outputs: got %b expected all zero",
                     {ro_en, ram_wren, ram_addr, rd_valid, rd_data, rd_last, busy, done, health_fail});
        else passed++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({ro_en, busy} !== 2'b00) $display("FAIL reset_beats_start: got %b expected 00", {ro_en, busy});
        else passed++;
        rst = 1'b0;
        sample_in = 1'b1;
        #1;
        checks++;
        if (ram_data !== 1'b1) $display("FAIL ram_data_passthrough: got %b expected 1", ram_data);
        else passed++;
        sample_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({ro_en, busy, done} !== 3'b000) $display("FAIL idle_hold: got %b expected 000", {ro_en, busy, done});
        else passed++;
    endtask

    task automatic test_capture();
        logic       s [DEPTH];
        int         run, fail_cyc, exp_addr;
        logic       wr, exp_ro;
        logic [8:0] got, exp;
        for (int p = 0; p < 4; p++) begin
            fail_cyc = 1 << 20;
            run = 0;
            for (int j = 0; j < DEPTH; j++) begin
                case (p)
                    0: s[j] = j[0];
                    1: s[j] = 1'b1;
                    2: s[j] = 1'($urandom_range(0, 1));
                    default: s[j] = (j == 0 || $urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : s[j-1];
                endcase
                run = (j > 0 && s[j] == s[j-1]) ? run + 1 : 1;
                if (run >= REP_LIMIT && fail_cyc > WARMUP_CYC + j + 2) fail_cyc = WARMUP_CYC + j + 2;
            end
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int k = 0; k < NCYC; k++) begin
                wr       = (k >= WARMUP_CYC) && (k < WARMUP_CYC + DEPTH);
                exp_ro   = (k < WARMUP_CYC + DEPTH);
                exp_addr = wr ? k - WARMUP_CYC : 0;
                got = {ro_en, ram_wren, ram_addr, busy, done, health_fail};
                exp = {exp_ro, wr, ADDR_W'(exp_addr), exp_ro, !exp_ro, (k >= fail_cyc)};
                checks++;
                if (got !== exp)
                    $display("FAIL capture p%0d cyc %0d {ro,wren,addr,busy,done,hf}: got %b expected %b", p, k, got, exp);
                else passed++;
                sample_in = wr ? s[k - WARMUP_CYC] : 1'($urandom_range(0, 1));
                if (wr) begin
                    #1;
                    checks++;
                    if (ram_data !== s[k - WARMUP_CYC])
                        $display("FAIL capture_data p%0d cyc %0d: got %b expected %b", p, k, ram_data, s[k - WARMUP_CYC]);
                    else passed++;
                end
                @(negedge clk);
            end
            for (int j = 0; j < DEPTH; j++) begin
                checks++;
                if (mem[j] !== s[j]) $display("FAIL capture_mem p%0d addr %0d: got %b expected %b", p, j, mem[j], s[j]);
                else passed++;
            end
        end
    endtask

    task automatic test_readout(input logic [7:0] pat, input logic rand_ready);
        logic [DEPTH-1:0] bits;
        int               nwr, got, stall, last_hs, gap, exp_gap;
        logic             f0, ok, holding, held;
        for (int i = 0; i < DEPTH; i++) bits[i] = pat[7 - i];
        do_capture(bits, nwr, f0, ok);
        checks++;
        if (!ok || nwr != DEPTH) $display("FAIL readout_setup: got ok=%b writes=%0d expected ok=1 writes=%0d", ok, nwr, DEPTH);
        else passed++;
        rd_ready = 1'b0;
        @(negedge clk); rd_start = 1'b1;
        @(negedge clk); rd_start = 1'b0;
        got = 0; stall = 0; last_hs = 0; holding = 1'b0; held = 1'b0;
        for (int cyc = 0; cyc < 300 && got < DEPTH; cyc++) begin
            if (rd_valid) begin
                if (!holding) begin
                    exp_gap = (got == 0) ? 2 : 3;
                    gap     = cyc - last_hs;
                    checks++;
                    if (gap != exp_gap) $display("FAIL readout_latency bit %0d: got %0d cycles expected %0d", got, gap, exp_gap);
                    else passed++;
                end else begin
                    checks++;
                    if (rd_data !== held) $display("FAIL readout_stall_stable bit %0d: got %b expected %b", got, rd_data, held);
                    else passed++;
                end
                checks++;
                if (rd_last !== (got == DEPTH - 1))
                    $display("FAIL readout_last bit %0d: got %b expected %b", got, rd_last, (got == DEPTH - 1));
                else passed++;
                rd_ready = rand_ready ? ($urandom_range(0, 2) != 0) : !(got == 2 && stall < 4);
                if (rd_ready) begin
                    checks++;
                    if (rd_data !== bits[got]) $display("FAIL readout_data bit %0d: got %b expected %b", got, rd_data, bits[got]);
                    else passed++;
                    got++;
                    last_hs = cyc;
                    holding = 1'b0;
                end else begin
                    stall++;
                    holding = 1'b1;
                    held    = rd_data;
                end
            end else begin
                rd_ready = 1'($urandom_range(0, 1));
                holding  = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (got != DEPTH) $display("FAIL readout_count: got %0d bits expected %0d", got, DEPTH);
        else passed++;
        checks++;
        if ({rd_valid, done, busy} !== 3'b010) $display("FAIL readout_end {valid,done,busy}: got %b expected 010", {rd_valid, done, busy});
        else passed++;
        rd_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic found, f0, ok;
        int   nwr;
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        checks++;
        if ({ro_en, busy, done} !== 3'b000) $display("FAIL abort_beats_start: got %b expected 000", {ro_en, busy, done});
        else passed++;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (ram_wren && ram_addr == 3) begin
                found = 1'b1;
                break;
            end
            sample_in = c[0];
            @(negedge clk);
        end
        checks++;
        if (!found) $display("FAIL abort_reach_addr3: got timeout expected write at address 3");
        else passed++;
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if ({ro_en, ram_wren, ram_addr, done, busy, rd_valid} !== '0)
            $display("FAIL abort_outputs: got %b expected all zero", {ro_en, ram_wren, ram_addr, done, busy, rd_valid});
        else passed++;
        sample_in = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (ram_wren && ram_addr == 6) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found || health_fail !== 1'b1) $display("FAIL abort_hf_before: got found=%b hf=%b expected 1 1", found, health_fail);
        else passed++;
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if ({health_fail, ro_en} !== 2'b10) $display("FAIL abort_hf_retained {hf,ro_en}: got %b expected 10", {health_fail, ro_en});
        else passed++;
        do_capture(8'b1010_1010, nwr, f0, ok);
        checks++;
        if ({ok, f0, health_fail} !== 3'b100 || nwr != DEPTH)
            $display("FAIL abort_rerun {ok,hf0,hf}: got %b writes %0d expected 100 writes %0d", {ok, f0, health_fail}, nwr, DEPTH);
        else passed++;
    endtask

    task automatic test_start_with_rd_start();
        logic seen_valid;
        int   nwr, done_cyc;
        @(negedge clk); start = 1'b1; rd_start = 1'b1; rd_ready = 1'b1;
        @(negedge clk); start = 1'b0; rd_start = 1'b0;
        checks++;
        if ({ro_en, busy, done} !== 3'b110) $display("FAIL both_start_warmup {ro,busy,done}: got %b expected 110", {ro_en, busy, done});
        else passed++;
        seen_valid = 1'b0; nwr = 0; done_cyc = -1;
        for (int c = 0; c < 60; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            seen_valid |= rd_valid;
            if (ram_wren) nwr++;
            sample_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++;
        if (seen_valid) $display("FAIL both_start_no_valid: got rd_valid=1 expected 0");
        else passed++;
        checks++;
        if (done_cyc != WARMUP_CYC + DEPTH || nwr != DEPTH)
            $display("FAIL both_start_capture: got done at %0d writes %0d expected %0d and %0d", done_cyc, nwr, WARMUP_CYC + DEPTH, DEPTH);
        else passed++;
        rd_ready = 1'b0;
    endtask

    task automatic test_ignore_and_rst();
        int nwr, done_cyc;
        sample_in = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nwr = 0; done_cyc = -1;
        for (int c = 0; c < 60; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (ram_wren) nwr++;
            start    = (c == 1 || c == WARMUP_CYC + 2);
            rd_start = start;
            @(negedge clk);
        end
        start = 1'b0; rd_start = 1'b0;
        checks++;
        if (done_cyc != WARMUP_CYC + DEPTH || nwr != DEPTH)
            $display("FAIL ignore_start: got done at %0d writes %0d expected %0d and %0d", done_cyc, nwr, WARMUP_CYC + DEPTH, DEPTH);
        else passed++;
        @(negedge clk); rd_start = 1'b1;
        @(negedge clk); rd_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_valid, busy, health_fail} !== 3'b111) $display("FAIL rst_pre {valid,busy,hf}: got %b expected 111", {rd_valid, busy, health_fail});
        else passed++;
        rst = 1'b1; sample_in = 1'b0;
        @(negedge clk); rst = 1'b0;
        checks++;
        if ({ro_en, ram_wren, ram_addr, ram_data, rd_valid, rd_data, rd_last, busy, done, health_fail} !== '0)
            $display("FAIL rst_mid_readout: got %b expected all zero",
                     {ro_en, ram_wren, ram_addr, ram_data, rd_valid, rd_data, rd_last, busy, done, health_fail});
        else passed++;
        @(negedge clk); rd_start = 1'b1;
        @(negedge clk); rd_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_valid, busy} !== 2'b00) $display("FAIL idle_ignores_rd_start: got %b expected 00", {rd_valid, busy});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_readout(8'b1011_0010, 1'b0);
        test_readout(8'($urandom), 1'b1);
        test_abort();
        test_start_with_rd_start();
        test_ignore_and_rst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
